// File: rtl/interp2_linear_pkg.sv
// rtl/interp2_linear_pkg.sv - shared types and helpers for the linear x2 interpolator
package interp2_linear_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREV = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    // One guard bit so a+b+1 never overflows before the halving shift
    function automatic int mid_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/interp2_mid.sv
// rtl/interp2_mid.sv - combinational midpoint (a+b+1)>>>1, rounding half toward +inf
module interp2_mid
    import interp2_linear_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    localparam int MW = mid_width(WIDTH);

    logic [MW-1:0] sum;

    always_comb begin
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b} + MW'(1);
        // Dropping bit 0 of the extended sum is the arithmetic shift; the result always fits
        y   = sum[MW-1:1];
    end

endmodule

// File: rtl/interp2_linear.sv
// rtl/interp2_linear.sv - stream interpolator by 2 with linear midpoint insertion
module interp2_linear
    import interp2_linear_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] i_tdata,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    output logic signed [WIDTH-1:0] o_tdata,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready
);

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic signed [WIDTH-1:0] prev_q, prev_d;
    logic signed [WIDTH-1:0] hold_q, hold_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;
    logic                    hold_last_q, hold_last_d;
    logic signed [WIDTH-1:0] mid_y;
    logic                    free;
    logic                    accept;

    interp2_mid #(.WIDTH(WIDTH)) u_mid (
        .a (prev_q),
        .b (i_tdata),
        .y (mid_y)
    );

    assign free     = !tvalid_q || o_tready;
    assign i_tready = free && (state_q == ST_IDLE || state_q == ST_PREV);
    assign accept   = i_tvalid && i_tready;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        prev_d      = prev_q;
        hold_d      = hold_q;
        tlast_d     = tlast_q;
        tvalid_d    = tvalid_q;
        hold_last_d = hold_last_q;
        // A free slot that is not reloaded this cycle empties
        if (free) begin
            tvalid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    out_d    = i_tdata;
                    prev_d   = i_tdata;
                    tlast_d  = i_tlast;
                    tvalid_d = 1'b1;
                    state_d  = i_tlast ? ST_IDLE : ST_PREV;
                end
            end
            ST_PREV: begin
                if (accept) begin
                    out_d       = mid_y;
                    tlast_d     = 1'b0;
                    hold_d      = i_tdata;
                    hold_last_d = i_tlast;
                    tvalid_d    = 1'b1;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (free) begin
                    out_d    = hold_q;
                    prev_d   = hold_q;
                    tlast_d  = hold_last_q;
                    tvalid_d = 1'b1;
                    state_d  = hold_last_q ? ST_IDLE : ST_PREV;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            prev_q      <= '0;
            hold_q      <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            hold_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            prev_q      <= prev_d;
            hold_q      <= hold_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            hold_last_q <= hold_last_d;
        end
    end

    assign o_tdata  = out_q;
    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;

endmodule

// File: tb/tb_interp2_linear.sv
// tb/tb_interp2_linear.sv - self-checking bench for interp2_linear
module tb_interp2_linear;

    localparam int WIDTH = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clear;
    logic signed [WIDTH-1:0] i_tdata;
    logic                    i_tlast;
    logic                    i_tvalid;
    logic                    i_tready;
    logic signed [WIDTH-1:0] o_tdata;
    logic                    o_tlast;
    logic                    o_tvalid;
    logic                    o_tready;

    interp2_linear #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit l;
    } smp_t;

    smp_t in_q[$];
    smp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   ready_mode = 0;   // 0: always 1, 1: random, 2: always 0, 3: driven by test
    int   cyc = 0;
    int   out_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mid(input int a, input int b);
        return (a + b + 1) >>> 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        case (ready_mode)
            0: o_tready = 1'b1;
            1: o_tready = 1'($urandom_range(0, 1));
            2: o_tready = 1'b0;
            default: ;
        endcase
    end

    // Output scoreboard, hold-stability and EMIT-stall monitor
    bit stall_p = 0;
    int last_d = 0;
    bit last_l = 0;
    bit emit_chk = 0;
    int in_pos = 0;
    initial forever begin
        @(negedge clk);
        if (rst || clear) begin
            stall_p  = 0;
            emit_chk = 0;
            in_pos   = 0;
        end else begin
            if (emit_chk) check("emit_i_tready", int'(i_tready), 0);
            if (stall_p) begin
                check("hold_tvalid", int'(o_tvalid), 1);
                check("hold_tdata", int'(o_tdata), last_d);
                check("hold_tlast", int'(o_tlast), int'(last_l));
            end
            if (o_tvalid && o_tready) begin
                check("output_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("out_tdata", int'(o_tdata), exp_q[0].d);
                    check("out_tlast", int'(o_tlast), int'(exp_q[0].l));
                    void'(exp_q.pop_front());
                end
                out_cnt++;
                if (out_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            stall_p  = o_tvalid && !o_tready;
            last_d   = int'(o_tdata);
            last_l   = o_tlast;
            emit_chk = 0;
            if (i_tvalid && i_tready) begin
                emit_chk = (in_pos > 0);
                in_pos   = i_tlast ? 0 : in_pos + 1;
            end
        end
    end

    task automatic queue_in(input int n, input int a, input int b = 0, input int c = 0);
        int v[3];
        v[0] = a; v[1] = b; v[2] = c;
        for (int i = 0; i < n; i++) in_q.push_back('{d: v[i], l: (i == n - 1)});
    endtask

    task automatic exp_pkt(input int n, input int e0, input int e1 = 0, input int e2 = 0,
                           input int e3 = 0, input int e4 = 0);
        int v[5];
        v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3; v[4] = e4;
        for (int i = 0; i < n; i++) exp_q.push_back('{d: v[i], l: (i == n - 1)});
    endtask

    task automatic drive_all(input bit rnd_valid);
        int guard = 0;
        bit acc;
        while (in_q.size() > 0 && guard < 40000) begin
            i_tdata  = WIDTH'(in_q[0].d);
            i_tlast  = in_q[0].l;
            i_tvalid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = i_tvalid && i_tready;
            step();
            if (acc) void'(in_q.pop_front());
            guard++;
        end
        i_tvalid = 1'b0;
        check("inputs_consumed", in_q.size(), 0);
        in_q.delete();
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() > 0 && g < 2000) begin
            step();
            g++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) step();
    endtask

    task automatic abort_in_emit(input bit use_clear);
        ready_mode = 3;
        o_tready   = 1'b1;
        exp_pkt(1, 10);
        exp_q[0].l = 1'b0;
        i_tdata  = 16'sd10; i_tlast = 1'b0; i_tvalid = 1'b1;
        step();
        i_tdata  = 16'sd20;
        step();
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        step();
        @(negedge clk);
        check("stall_i_tready", int'(i_tready), 0);
        check("stall_tvalid", int'(o_tvalid), 1);
        step();
        if (use_clear) clear = 1'b1; else rst = 1'b1;
        step();
        rst = 1'b0; clear = 1'b0;
        @(negedge clk);
        check("abort_tvalid", int'(o_tvalid), 0);
        check("abort_i_tready", int'(i_tready), 1);
        check("abort_tdata", int'(o_tdata), 0);
        check("abort_tlast", int'(o_tlast), 0);
        check("abort_scoreboard", exp_q.size(), 0);
        exp_q.delete();
        ready_mode = 0;
        step();
        step();
        queue_in(2, 5, 6);
        exp_pkt(3, 5, 6, 6);
        drive_all(1'b0);
        wait_drain();
    endtask

    initial begin
        int v[5];
        int n;
        rst = 1'b1; clear = 1'b0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_tvalid", int'(o_tvalid), 0);
        check("rst_tdata", int'(o_tdata), 0);
        check("rst_tlast", int'(o_tlast), 0);
        check("rst_i_tready", int'(i_tready), 1);
        step();
        rst = 1'b0;
        step();

        out_cnt = 0;
        queue_in(3, 100, 200, -50);
        exp_pkt(5, 100, 150, 200, 75, -50);
        drive_all(1'b0);
        wait_drain();
        check("tp_count", out_cnt, 5);
        check("tp_span", last_cyc - first_cyc, 4);

        queue_in(2, 1, 2);             exp_pkt(3, 1, 2, 2);
        queue_in(2, -1, -2);           exp_pkt(3, -1, -1, -2);
        queue_in(2, 3, 4);             exp_pkt(3, 3, 4, 4);
        queue_in(2, 32767, 32767);     exp_pkt(3, 32767, 32767, 32767);
        queue_in(2, -32768, -32768);   exp_pkt(3, -32768, -32768, -32768);
        queue_in(2, 32767, -32768);    exp_pkt(3, 32767, 0, -32768);
        queue_in(1, 7);                exp_pkt(1, 7);
        queue_in(2, 9, 11);            exp_pkt(3, 9, 10, 11);
        drive_all(1'b0);
        wait_drain();

        ready_mode = 1;
        queue_in(3, 100, 200, -50);
        exp_pkt(5, 100, 150, 200, 75, -50);
        drive_all(1'b1);
        wait_drain();

        for (int p = 0; p < 1000; p++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
            for (int i = 0; i < n; i++) begin
                in_q.push_back('{d: v[i], l: (i == n - 1)});
                exp_q.push_back('{d: v[i], l: (i == n - 1)});
                if (i < n - 1) exp_q.push_back('{d: mid(v[i], v[i + 1]), l: 1'b0});
            end
        end
        drive_all(1'b1);
        wait_drain();
        ready_mode = 0;
        step();

        abort_in_emit(1'b0);
        abort_in_emit(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interp2_linear.md
Name: interp2_linear

Overview:
- Stream interpolator by 2 with linear midpoint insertion; the inverse direction of the two-input add-and-round reduction.
- For each packet of input samples x0..x(N-1) it emits x0, mid(x0,x1), x1, mid(x1,x2), …, x(N-1), giving 2N-1 outputs.
- Sits in the DUC path ahead of CIC/halfband stages.
- AXI-stream style valid/ready on both sides, with a single registered output stage.

Parameters:
WIDTH, 16, signed sample width, two's complement

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
clear  in  1  synchronous flush: return to IDLE, drop held/output data
i_tdata  in  WIDTH  input sample, signed
i_tlast  in  1  last sample of packet
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  WIDTH  output sample, signed
o_tlast  out  1  last output of packet
o_tvalid  out  1  output valid
o_tready  in  1  downstream ready

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: on rst (and identically on clear), state=IDLE; o_tvalid, o_tlast and o_tdata are 0; prev, hold and hold_last are 0. rst has priority over clear; clear has priority over all datapath activity.
- Output slot: the output register is free when `!o_tvalid || o_tready`. A transfer happens when the slot is free and a new value is loaded. If nothing is loaded that cycle and o_tready=1, o_tvalid drops to 0.
- While o_tvalid=1 and o_tready=0, o_tdata and o_tlast hold stable.
- i_tready = free && (state==IDLE || state==PREV); combinational, with no dependence on i_tvalid.
- Midpoint rule: mid(a,b) = (sext(a) + sext(b) + 1) >>> 1.
  - Computed in WIDTH+1 bits with an arithmetic shift, i.e. round half toward +inf.
  - The result always fits WIDTH; no saturation logic is needed.
- State IDLE (no previous sample): on input accept, out<=x, prev<=x, o_tlast<=i_tlast. Next state is IDLE if i_tlast=1, else PREV.
- State PREV (prev already emitted): on input accept, out<=mid(prev,x), o_tlast<=0, hold<=x, hold_last<=i_tlast. Next state is EMIT.
- State EMIT (i_tready=0): when free, out<=hold, prev<=hold, o_tlast<=hold_last. Next state is IDLE if hold_last=1, else PREV.
- Latency: an accepted input appears on o_tdata the next cycle (registered), as x in IDLE or as the midpoint in PREV.
- Throughput: with o_tready held high and input always valid, output runs at 1 sample/cycle and input at 1 sample per 2 cycles (steady state after the first packet sample).
- Packet boundary: a single-sample packet (tlast on x0) emits one output carrying tlast. No midpoint is ever formed across a tlast boundary.
- Midpoint outputs never carry tlast.
- Backpressure in EMIT: the held sample waits indefinitely; input stays stalled.
- rst or clear mid-packet: the partial packet is discarded with no tlast generated. The next accepted sample is treated as x0.
- Inputs with i_tvalid=0 change nothing; i_tdata/i_tlast are ignored when not accepted.

Decomposition:
- Shared DSP package holds:
  - state enum IDLE/PREV/EMIT (2-bit encoding);
  - the function or constant for the midpoint rounding width (WIDTH+1).
- One natural sub-module, interp2_mid: purely combinational mid(a,b) per the rule above, reusable by other interpolators.
- The FSM, hold registers and output stage live in interp2_linear.

Test Plan:
- Packet {100, 200, -50 tlast}, o_tready=1 → outputs 100, 150, 200, 75, -50. tlast only on -50. Five outputs on consecutive cycles after the first.
- Rounding: packet {1, 2 tlast} → 1, 2, 2. Packet {-1, -2 tlast} → -1, -1, -2. Packet {3, 4 tlast} → 3, 4, 4.
- Extremes: {32767, 32767 tlast} → 32767, 32767, 32767. {-32768, -32768 tlast} → -32768, -32768, -32768. {32767, -32768 tlast} → 32767, 0, -32768.
- Single-sample packet {7 tlast} followed by {9, 11 tlast} → 7(tlast), 9, 10, 11(tlast). There is no midpoint between 7 and 9.
- Backpressure: random o_tready (~50% duty) with random i_tvalid over 1000 random packets → output matches the reference model exactly. o_tdata/o_tlast are stable while o_tvalid && !o_tready, and i_tready=0 in EMIT.
- Assert rst (then, separately, clear) while in EMIT mid-packet → o_tvalid=0 next cycle, state IDLE, i_tready=1. The following packet {5, 6 tlast} → 5, 6, 6 with no stale data.
